// File: rtl/inst_issue_queue.sv
// Instruction issue queue: unpacks 128-bit fetch packages into per-instruction
// entries in a circular buffer and presents the two oldest to dual-issue decode.
module inst_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               pkg_valid_i,
    input  logic [127:0]       pkg_i,
    output logic               stall_o,
    input  logic [1:0]         issue_cnt_i,
    output logic               out0_valid_o,
    output logic [31:0]        out0_pc_o,
    output logic [31:0]        out0_inst_o,
    output logic               out0_is_branch_o,
    output logic               out0_pred_taken_o,
    output logic               out1_valid_o,
    output logic [31:0]        out1_pc_o,
    output logic [31:0]        out1_inst_o,
    output logic               out1_is_branch_o,
    output logic               out1_pred_taken_o,
    output logic [PTR_W:0]     count_o
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br;
        logic        pt;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_v1;
    logic             w_v2;
    logic             w_keep2;
    logic             w_push;
    logic [1:0]       w_wr;
    logic [1:0]       w_rd;
    logic [1:0]       w_ic_clamp;
    logic [PTR_W-1:0] w_head1;
    logic [PTR_W-1:0] w_b_idx;
    entry_t           w_entry_a;
    entry_t           w_entry_b;
    entry_t           w_rd0;
    entry_t           w_rd1;
    logic             w_unused_bits;

    assign w_v1    = pkg_i[31];
    assign w_v2    = pkg_i[30];
    // A predicted-taken first slot redirects fetch, so the second slot is off-path.
    assign w_keep2 = w_v2 & ~(w_v1 & pkg_i[29] & pkg_i[28]);
    assign stall_o = (r_count > (PTR_W+1)'(DEPTH - 2));
    assign w_push  = pkg_valid_i & ~stall_o & ~flush_i;

    assign w_entry_a = '{pc: pkg_i[127:96], inst: pkg_i[95:64], br: pkg_i[29], pt: pkg_i[28]};
    assign w_entry_b = '{pc: pkg_i[127:96] + 32'd4, inst: pkg_i[63:32], br: pkg_i[27], pt: pkg_i[26]};
    assign w_b_idx   = w_v1 ? (r_tail + PTR_W'(1)) : r_tail;
    assign w_head1   = r_head + PTR_W'(1);
    assign w_unused_bits = ^pkg_i[25:0];

    // Write and read counts for this cycle; pops are limited to what is held.
    always_comb begin
        w_wr       = 2'd0;
        w_rd       = 2'd0;
        w_ic_clamp = (issue_cnt_i == 2'd3) ? 2'd2 : issue_cnt_i;
        if (w_push) begin
            w_wr = {1'b0, w_v1} + {1'b0, w_keep2};
        end else begin
            w_wr = 2'd0;
        end
        if ((PTR_W+1)'(w_ic_clamp) > r_count) begin
            w_rd = r_count[1:0];
        end else begin
            w_rd = w_ic_clamp;
        end
    end

    // Head/tail/occupancy update; flush empties the queue ahead of push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {(PTR_W+1){1'b0}};
        end else if (flush_i) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {(PTR_W+1){1'b0}};
        end else begin
            r_head  <= r_head + PTR_W'(w_rd);
            r_tail  <= r_tail + PTR_W'(w_wr);
            r_count <= r_count + (PTR_W+1)'(w_wr) - (PTR_W+1)'(w_rd);
        end
    end

    // Entry storage; left uninitialised since valids gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (w_v1) begin
                r_mem[r_tail] <= w_entry_a;
            end
            if (w_keep2) begin
                r_mem[w_b_idx] <= w_entry_b;
            end
        end
    end

    assign w_rd0 = r_mem[r_head];
    assign w_rd1 = r_mem[w_head1];

    assign out0_valid_o      = (r_count >= (PTR_W+1)'(1)) & ~flush_i;
    assign out1_valid_o      = (r_count >= (PTR_W+1)'(2)) & ~flush_i;
    assign out0_pc_o         = w_rd0.pc;
    assign out0_inst_o       = w_rd0.inst;
    assign out0_is_branch_o  = w_rd0.br;
    assign out0_pred_taken_o = w_rd0.pt;
    assign out1_pc_o         = w_rd1.pc;
    assign out1_inst_o       = w_rd1.inst;
    assign out1_is_branch_o  = w_rd1.br;
    assign out1_pred_taken_o = w_rd1.pt;
    assign count_o           = r_count;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Scoreboard bench for inst_issue_queue: expected entries are queued when a
// package is accepted and compared against out0/out1 every cycle.
module tb_inst_issue_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         pkg_valid_i;
    logic [127:0] pkg_i;
    logic         stall_o;
    logic [1:0]   issue_cnt_i;
    logic         out0_valid_o, out1_valid_o;
    logic [31:0]  out0_pc_o, out0_inst_o, out1_pc_o, out1_inst_o;
    logic         out0_is_branch_o, out0_pred_taken_o, out1_is_branch_o, out1_pred_taken_o;
    logic [3:0]   count_o;

    int           n_checks = 0;
    int           n_fail = 0;
    int           m_head = 0;
    logic [65:0]  sb[$];
    logic [31:0]  pc_nx;
    logic [127:0] held;

    inst_issue_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .pkg_valid_i(pkg_valid_i), .pkg_i(pkg_i),
        .stall_o(stall_o), .issue_cnt_i(issue_cnt_i),
        .out0_valid_o(out0_valid_o), .out0_pc_o(out0_pc_o), .out0_inst_o(out0_inst_o),
        .out0_is_branch_o(out0_is_branch_o), .out0_pred_taken_o(out0_pred_taken_o),
        .out1_valid_o(out1_valid_o), .out1_pc_o(out1_pc_o), .out1_inst_o(out1_inst_o),
        .out1_is_branch_o(out1_is_branch_o), .out1_pred_taken_o(out1_pred_taken_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                                        input logic v1, input logic v2, input logic b1, input logic p1,
                                        input logic b2, input logic p2);
        return {pc, i1, i2, v1, v2, b1, p1, b2, p2, 26'd0};
    endfunction

    function automatic logic [127:0] full(input logic [31:0] pc);
        return mk(pc, pc ^ 32'h0000_0013, pc ^ 32'h0013_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    // One clock: drive inputs, check outputs at negedge, then advance the model.
    task automatic cycle(input logic pv, input logic [127:0] pk, input logic [1:0] ic, input logic fl);
        int sz;
        int rd;
        logic keep2;
        pkg_valid_i = pv; pkg_i = pk; issue_cnt_i = ic; flush_i = fl;
        @(negedge clk);
        sz = sb.size();
        chk_eq("count", 66'(count_o), 66'(sz));
        chk_eq("stall", 66'(stall_o), 66'(sz > 6));
        chk_eq("out0_valid", 66'(out0_valid_o), 66'((sz >= 1) && !fl));
        chk_eq("out1_valid", 66'(out1_valid_o), 66'((sz >= 2) && !fl));
        if (sz >= 1 && !fl)
            chk_eq("out0_entry", {out0_pc_o, out0_inst_o, out0_is_branch_o, out0_pred_taken_o}, sb[0]);
        if (sz >= 2 && !fl)
            chk_eq("out1_entry", {out1_pc_o, out1_inst_o, out1_is_branch_o, out1_pred_taken_o}, sb[1]);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_head = 0;
        end else begin
            rd = (ic == 2'd3) ? 2 : int'(ic);
            if (rd > sz) rd = sz;
            for (int k = 0; k < rd; k++) void'(sb.pop_front());
            m_head = (m_head + rd) % 8;
            if (pv && sz <= 6) begin
                keep2 = pk[30] && !(pk[31] && pk[29] && pk[28]);
                if (pk[31]) sb.push_back({pk[127:96], pk[95:64], pk[29], pk[28]});
                if (keep2)  sb.push_back({pk[127:96] + 32'd4, pk[63:32], pk[27], pk[26]});
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; pkg_valid_i = 1'b0; pkg_i = 128'd0; issue_cnt_i = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then the basic two-instruction push
        cycle(1'b1, mk(32'h8000_0000, 32'h0280_0421, 32'h0280_0842, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 2'd0, 1'b0);
        chk_eq("basic_count", 66'(count_o), 66'd2);
        chk_eq("basic_out0_inst", 66'(out0_inst_o), 66'h0280_0421);
        chk_eq("basic_out1_pc", 66'(out1_pc_o), 66'h8000_0004);
        chk_eq("basic_out1_inst", 66'(out1_inst_o), 66'h0280_0842);
        pc_nx = 32'h8000_0008;

        // Fill to full, hold a package under stall, then release it
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, full(pc_nx), 2'd0, 1'b0);
            pc_nx += 32'd8;
        end
        held = full(pc_nx);
        repeat (3) cycle(1'b1, held, 2'd0, 1'b0);
        cycle(1'b1, held, 2'd2, 1'b0);
        chk_eq("release_count", 66'(count_o), 66'd6);
        chk_eq("release_stall", 66'(stall_o), 66'd0);
        cycle(1'b1, held, 2'd0, 1'b0);
        pc_nx += 32'd8;
        chk_eq("refill_count", 66'(count_o), 66'd8);

        // Drain, including issue_cnt=3 and over-consume at empty
        for (int i = 0; i < 6; i++) cycle(1'b0, 128'd0, (i % 2 == 1) ? 2'd3 : 2'd2, 1'b0);

        // Predicted-taken first slot drops the second
        cycle(1'b1, mk(pc_nx, 32'h0000_0063, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 2'd0, 1'b0);
        pc_nx += 32'd8;
        chk_eq("pt_count", 66'(count_o), 66'd1);
        chk_eq("pt_flag", 66'(out0_pred_taken_o), 66'd1);
        chk_eq("pt_out1_valid", 66'(out1_valid_o), 66'd0);
        cycle(1'b0, 128'd0, 2'd1, 1'b0);

        // Steer head to 7, then concurrent push 2 / pop 2 across the wrap
        for (int k = 0; k < 16 && m_head != 7; k++) begin
            cycle(1'b1, mk(pc_nx, pc_nx ^ 32'h55, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 2'd1, 1'b0);
            pc_nx += 32'd8;
        end
        chk_eq("head_at_7", 66'(m_head), 66'd7);
        cycle(1'b1, full(pc_nx), 2'd0, 1'b0);
        pc_nx += 32'd8;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, full(pc_nx), 2'd2, 1'b0);
            pc_nx += 32'd8;
        end

        // Flush mid-stream at count 5 beats a push and a pop
        for (int k = 0; k < 8 && sb.size() > 0; k++) cycle(1'b0, 128'd0, 2'd2, 1'b0);
        cycle(1'b1, full(pc_nx), 2'd0, 1'b0); pc_nx += 32'd8;
        cycle(1'b1, full(pc_nx), 2'd0, 1'b0); pc_nx += 32'd8;
        cycle(1'b1, mk(pc_nx, 32'h77, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 2'd0, 1'b0);
        pc_nx += 32'd8;
        chk_eq("preflush_count", 66'(count_o), 66'd5);
        cycle(1'b1, full(pc_nx), 2'd1, 1'b1);
        chk_eq("flush_count", 66'(count_o), 66'd0);

        // Second-slot-only package, then over-consume
        cycle(1'b1, mk(32'h8000_0010, 32'h0, 32'h00A0_0093, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 2'd0, 1'b0);
        chk_eq("partial_pc", 66'(out0_pc_o), 66'h8000_0014);
        chk_eq("partial_count", 66'(count_o), 66'd1);
        cycle(1'b0, 128'd0, 2'd2, 1'b0);
        cycle(1'b0, 128'd0, 2'd0, 1'b0);

        // Reset wins over flush with a non-empty queue
        cycle(1'b1, full(pc_nx), 2'd0, 1'b0);
        rst = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        m_head = 0;
        cycle(1'b0, 128'd0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
